risc_datapath: RTL and testbench

Datapath companion to the 8-state instruction-sequencing controller of the accumulator RISC core. It holds the program counter (PC), instruction register (IR), accumulator (AC), ALU and memory-address mux. It consumes the controller's strobes and returns `opcode` and `zero` to it. It also drives the single-port program/data memory (32 × 8, asynchronous read).

---
 rtl/risc_datapath_if.sv | 19 +
 rtl/risc_datapath.sv | 91 +++++++++
 tb/tb_risc_datapath.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_datapath_if.sv
// Memory bus between risc_datapath (master) and the single-port 32x8
// program/data memory (slave, asynchronous read).
interface risc_datapath_if;
    logic [4:0] mem_addr_o;
    logic [7:0] mem_rdata_i;
    logic [7:0] mem_wdata_o;
    logic       mem_rd_o;
    logic       mem_wr_o;

    modport master (
        output mem_addr_o, mem_wdata_o, mem_rd_o, mem_wr_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_addr_o, mem_wdata_o, mem_rd_o, mem_wr_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/risc_datapath.sv
// Accumulator RISC datapath: PC, IR, AC, ALU, address mux and halt latch.
// Optional build macro DP_ACC_SAT_EN makes ADD saturate at 8'hFF instead of wrapping.
module risc_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        load_ir,
    input  logic        halt,
    input  logic        inc_pc,
    input  logic        load_ac,
    input  logic        load_pc,
    input  logic        mem_wr,
    output logic [2:0]  opcode,
    output logic        zero,
    output logic [4:0]  pc_o,
    output logic [7:0]  ac_o,
    output logic        halted_o,
    risc_datapath_if.master mem
);
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;

    logic [4:0] pc;
    logic [7:0] ir;
    logic [7:0] ac;
    logic [2:0] phase;
    logic       load_ac_q;
    logic [7:0] alu_result;
    logic [7:0] add_result;

`ifdef DP_ACC_SAT_EN
    logic [8:0] add_sum;
    assign add_sum    = {1'b0, ac} + {1'b0, mem.mem_rdata_i};
    assign add_result = add_sum[8] ? 8'hFF : add_sum[7:0];
`else
    assign add_result = ac + mem.mem_rdata_i;
`endif

    // NOTE: alu_result gets a default before the case so no opcode can infer a latch.
    always_comb begin
        alu_result = ac;
        case (opcode)
            OP_ADD:  alu_result = add_result;
            OP_AND:  alu_result = ac & mem.mem_rdata_i;
            OP_XOR:  alu_result = ac ^ mem.mem_rdata_i;
            OP_LDA:  alu_result = mem.mem_rdata_i;
            default: alu_result = ac;
        endcase
    end

    // NOTE: state uses non-blocking assignments; rst is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= 5'd0;
            ir        <= 8'd0;
            ac        <= 8'd0;
            phase     <= 3'd0;
            load_ac_q <= 1'b0;
            halted_o  <= 1'b0;
        end else begin
            if (halt)
                halted_o <= 1'b1;
            if (!halted_o) begin
                phase     <= phase + 3'd1;
                load_ac_q <= load_ac;
                if (load_ir)
                    ir <= mem.mem_rdata_i;
                // Only the first cycle of a load_ac run commits, so the ALU op is applied once.
                if (load_ac && !load_ac_q)
                    ac <= alu_result;
                if (!halt) begin
                    if (load_pc)
                        pc <= ir[4:0];
                    else if (inc_pc)
                        pc <= pc + 5'd1;
                end
            end
        end
    end

    assign opcode          = ir[7:5];
    assign zero            = (ac == 8'd0);
    assign pc_o            = pc;
    assign ac_o            = ac;
    assign mem.mem_addr_o  = phase[2] ? ir[4:0] : pc;
    assign mem.mem_wdata_o = ac;
    assign mem.mem_rd_o    = mem_rd & ~halted_o;
    assign mem.mem_wr_o    = mem_wr & ~halted_o;
endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: behaves as controller and memory,
// with an instruction-level model feeding expected-result queues.
module tb_risc_datapath;
    logic       clk = 1'b0;
    logic       rst;
    logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] pc_o;
    logic [7:0] ac_o;
    logic       halted_o;

    risc_datapath_if mem_bus ();

    risc_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rd   (mem_rd),
        .load_ir  (load_ir),
        .halt     (halt),
        .inc_pc   (inc_pc),
        .load_ac  (load_ac),
        .load_pc  (load_pc),
        .mem_wr   (mem_wr),
        .opcode   (opcode),
        .zero     (zero),
        .pc_o     (pc_o),
        .ac_o     (ac_o),
        .halted_o (halted_o),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] pc;
        logic [7:0] ac;
        logic       halted;
    } exp_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic [7:0] mem       [32];
    logic [7:0] model_mem [32];
    logic [4:0] model_pc;
    logic [7:0] model_ac;
    logic       model_halted;
    exp_t       exp_q[$];
    wr_t        wr_q[$];
    int         checks = 0;
    int         errors = 0;

    assign mem_bus.mem_rdata_i = mem[mem_bus.mem_addr_o];

    task automatic clear_strobes();
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = '0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            mem[i]       = 8'h00;
            model_mem[i] = 8'h00;
        end
    endtask

    task automatic put(input logic [4:0] a, input logic [7:0] d);
        mem[a]       = d;
        model_mem[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = 7'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        clear_strobes();
        model_pc     = 5'd0;
        model_ac     = 8'd0;
        model_halted = 1'b0;
        exp_q.delete();
        wr_q.delete();
    endtask

    // Controller behaviour for one phase, driven from the DUT's opcode/zero.
    task automatic set_strobes(input int p);
        logic [2:0] op;
        logic       aluop;
        op    = opcode;
        aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        clear_strobes();
        case (p)
            1: mem_rd = 1'b1;
            2, 3: begin mem_rd = 1'b1; load_ir = 1'b1; end
            4: begin inc_pc = 1'b1; halt = (op == 3'd0); end
            5: mem_rd = aluop;
            6: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (op == 3'd1) && zero;
                load_pc = (op == 3'd7);
            end
            7: begin
                mem_rd  = aluop;
                load_ac = aluop;
                load_pc = (op == 3'd7);
                mem_wr  = (op == 3'd6);
            end
            default: ;
        endcase
    endtask

    // Instruction-level reference: pushes the expected architectural state.
    task automatic model_step(output logic is_hlt);
        logic [2:0] op;
        logic [4:0] a;
        logic [7:0] b;
        logic [8:0] sum;
        wr_t        w;
        exp_t       e;
        op     = model_mem[model_pc][7:5];
        a      = model_mem[model_pc][4:0];
        b      = model_mem[a];
        is_hlt = (op == 3'd0);
        case (op)
            3'd0: model_halted = 1'b1;
            3'd1: model_pc = model_pc + ((model_ac == 8'd0) ? 5'd2 : 5'd1);
            3'd2: begin
                sum = {1'b0, model_ac} + {1'b0, b};
`ifdef DP_ACC_SAT_EN
                model_ac = sum[8] ? 8'hFF : sum[7:0];
`else
                model_ac = sum[7:0];
`endif
                model_pc = model_pc + 5'd1;
            end
            3'd3: begin model_ac = model_ac & b; model_pc = model_pc + 5'd1; end
            3'd4: begin model_ac = model_ac ^ b; model_pc = model_pc + 5'd1; end
            3'd5: begin model_ac = b;            model_pc = model_pc + 5'd1; end
            3'd6: begin
                model_mem[a] = model_ac;
                w.addr = a;
                w.data = model_ac;
                wr_q.push_back(w);
                model_pc = model_pc + 5'd1;
            end
            default: model_pc = a;
        endcase
        e.pc     = model_pc;
        e.ac     = model_ac;
        e.halted = model_halted;
        exp_q.push_back(e);
    endtask

    // Runs one 8-phase instruction starting at a negedge in phase 0.
    task automatic run_instr(input string name);
        logic is_hlt;
        exp_t e;
        wr_t  w;
        model_step(is_hlt);
        for (int p = 0; p < 8; p++) begin
            set_strobes(p);
            #1;
            if (mem_bus.mem_wr_o) begin
                checks++;
                if (wr_q.size() == 0 || p != 7) begin
                    errors++;
                    $display("FAIL %s store_timing: write at phase %0d with %0d queued, required phase 7 with 1 queued",
                             name, p, wr_q.size());
                end else begin
                    w = wr_q.pop_front();
                    if (mem_bus.mem_addr_o !== w.addr || mem_bus.mem_wdata_o !== w.data) begin
                        errors++;
                        $display("FAIL %s store_data: got addr %h data %h, required addr %h data %h",
                                 name, mem_bus.mem_addr_o, mem_bus.mem_wdata_o, w.addr, w.data);
                    end
                end
                mem[mem_bus.mem_addr_o] = mem_bus.mem_wdata_o;
            end
            if (is_hlt && p >= 4) begin
                checks++;
                if (halted_o !== (p >= 5)) begin
                    errors++;
                    $display("FAIL %s halt_phase: phase %0d halted_o=%b, required %b", name, p, halted_o, p >= 5);
                end
            end
            @(negedge clk);
        end
        clear_strobes();
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s store_missing: %0d writes pending, required 0", name, wr_q.size());
            wr_q.delete();
        end
        e = exp_q.pop_front();
        checks++;
        if (pc_o !== e.pc || ac_o !== e.ac || zero !== (e.ac == 8'd0) || halted_o !== e.halted) begin
            errors++;
            $display("FAIL %s state: got pc=%h ac=%h zero=%b halted=%b, required pc=%h ac=%h zero=%b halted=%b",
                     name, pc_o, ac_o, zero, halted_o, e.pc, e.ac, e.ac == 8'd0, e.halted);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = 7'($urandom);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = 7'($urandom);
            #1;
            checks++;
            if (pc_o !== 5'd0 || ac_o !== 8'd0 || zero !== 1'b1 || opcode !== 3'd0 ||
                halted_o !== 1'b0 || dut.phase !== 3'd0) begin
                errors++;
                $display("FAIL reset_state: got pc=%h ac=%h zero=%b opcode=%h halted=%b phase=%0d, required 0,0,1,0,0,0",
                         pc_o, ac_o, zero, opcode, halted_o, dut.phase);
            end
            checks++;
            if (mem_bus.mem_addr_o !== 5'd0 || mem_bus.mem_wdata_o !== 8'd0 ||
                mem_bus.mem_rd_o !== mem_rd || mem_bus.mem_wr_o !== mem_wr) begin
                errors++;
                $display("FAIL reset_bus: got addr=%h wdata=%h rd=%b wr=%b, required 0,0,%b,%b",
                         mem_bus.mem_addr_o, mem_bus.mem_wdata_o, mem_bus.mem_rd_o, mem_bus.mem_wr_o, mem_rd, mem_wr);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_lda_add();
        clear_mem();
        put(5'h00, 8'hBE);
        put(5'h01, 8'h5E);
        put(5'h1E, 8'h05);
        do_reset();
        run_instr("lda");
        run_instr("add_once");
    endtask

    task automatic test_alu_ops();
        clear_mem();
        put(5'h00, 8'hBD);
        put(5'h1D, 8'hF0);
        put(5'h01, 8'h5C);
        put(5'h1C, 8'h20);
        put(5'h02, 8'h7B);
        put(5'h1B, 8'h3C);
        put(5'h03, 8'h9A);
        put(5'h1A, 8'hFF);
        do_reset();
        run_instr("lda_f0");
        run_instr("add_overflow");
        run_instr("and");
        run_instr("xor");
    endtask

    task automatic test_skz();
        for (int z = 0; z < 2; z++) begin
            clear_mem();
            for (int i = 0; i < 3; i++) put(5'(i), 8'hBF);
            put(5'h03, 8'h20);
            put(5'h1F, (z == 0) ? 8'h00 : 8'h01);
            do_reset();
            for (int i = 0; i < 3; i++) run_instr("skz_setup");
            run_instr((z == 0) ? "skz_taken" : "skz_not_taken");
        end
    endtask

    task automatic test_jmp_wrap();
        clear_mem();
        for (int i = 0; i < 7; i++) put(5'(i), 8'hBE);
        put(5'h07, 8'hFF);
        put(5'h1F, 8'hBE);
        put(5'h1E, 8'h01);
        do_reset();
        for (int i = 0; i < 7; i++) run_instr("jmp_setup");
        run_instr("jmp");
        run_instr("pc_wrap");
    endtask

    task automatic test_store_halt();
        clear_mem();
        put(5'h00, 8'hBE);
        put(5'h1E, 8'hA5);
        put(5'h01, 8'hD0);
        put(5'h02, 8'h00);
        do_reset();
        run_instr("sto_setup");
        run_instr("sto");
        run_instr("hlt");
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = '1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mem_bus.mem_rd_o !== 1'b0 || mem_bus.mem_wr_o !== 1'b0) begin
                errors++;
                $display("FAIL halted_bus: got rd=%b wr=%b, required 0 0", mem_bus.mem_rd_o, mem_bus.mem_wr_o);
            end
            @(negedge clk);
        end
        checks++;
        if (pc_o !== 5'h02 || ac_o !== 8'hA5 || halted_o !== 1'b1) begin
            errors++;
            $display("FAIL halted_frozen: got pc=%h ac=%h halted=%b, required 02 a5 1", pc_o, ac_o, halted_o);
        end
        checks++;
        if (mem[5'h10] !== 8'hA5) begin
            errors++;
            $display("FAIL sto_memory: got %h, required a5", mem[5'h10]);
        end
        clear_strobes();
        mem_rd = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (halted_o !== 1'b0 || mem_bus.mem_rd_o !== 1'b1 || pc_o !== 5'd0) begin
            errors++;
            $display("FAIL halt_release: got halted=%b rd=%b pc=%h, required 0 1 00", halted_o, mem_bus.mem_rd_o, pc_o);
        end
        rst = 1'b0;
        clear_strobes();
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        clear_mem();
        put(5'h00, 8'hBE);
        put(5'h1E, 8'h33);
        do_reset();
        for (int p = 0; p < 6; p++) begin
            set_strobes(p);
            @(negedge clk);
        end
        checks++;
        if (pc_o !== 5'd1 || opcode !== 3'd5) begin
            errors++;
            $display("FAIL mid_pre: got pc=%h opcode=%h, required 01 5", pc_o, opcode);
        end
        set_strobes(6);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_o !== 5'd0 || ac_o !== 8'd0 || opcode !== 3'd0 || dut.phase !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: got pc=%h ac=%h opcode=%h phase=%0d, required 00 00 0 0",
                     pc_o, ac_o, opcode, dut.phase);
        end
        rst = 1'b0;
        clear_strobes();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_mem();
        test_reset();
        test_lda_add();
        test_alu_ops();
        test_skz();
        test_jmp_wrap();
        test_store_halt();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
